// File: rtl/button_pkg.sv
// button_pkg: shared FSM state encodings and counter widths for button_event
`timescale 1ns/100ps
package button_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;
    localparam int HOLD_W  = 24;
    localparam int COUNT_W = 8;
endpackage

// File: rtl/button_event_edge_detect.sv
// edge_detect: keeps a registered copy of d and flags its rising/falling edges
//   CLK   - clock, rising edge
//   RST_N - asynchronous active-low reset (clears the stored copy)
//   d     - synchronous level input
//   rise  - d=1 while the stored previous sample is 0
//   fall  - d=0 while the stored previous sample is 1
`timescale 1ns/100ps
module edge_detect (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic pb_q;
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) pb_q <= 1'b0;
        else        pb_q <= d;
    // Strobes compare the current sample against the registered copy so the
    // FSM can act on the very edge that samples the transition.
    assign rise = d & ~pb_q;
    assign fall = ~d & pb_q;
endmodule

// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/release/long/repeat events
//   CLK          - clock, all state on the rising edge
//   RST_N        - asynchronous active-low reset
//   PB_debounced - debounced button level, 1 = pressed
//   PRESS        - one-cycle pulse after a press edge
//   RELEASE      - one-cycle pulse after a release edge
//   LONG         - one-cycle pulse when a press reaches LONG_CYCLES samples
//   REPEAT       - one-cycle pulse every REPEAT_CYCLES samples after LONG
//   HELD         - level, 1 while pressed or long-held
//   COUNT        - running count of PRESS and REPEAT pulses, wraps at 256
`timescale 1ns/100ps
module button_event
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = 1000,
    parameter int unsigned REPEAT_CYCLES = 250
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               PB_debounced,
    output logic               PRESS,
    output logic               RELEASE,
    output logic               LONG,
    output logic               REPEAT,
    output logic               HELD,
    output logic [COUNT_W-1:0] COUNT
);
    localparam logic [HOLD_W-1:0] LONG_M1   = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_M1 = HOLD_W'(REPEAT_CYCLES - 1);

    state_t            state;
    logic [HOLD_W-1:0] hold;
    logic              rise;
    logic              fall;

    edge_detect u_edge (
        .CLK  (CLK),
        .RST_N(RST_N),
        .d    (PB_debounced),
        .rise (rise),
        .fall (fall)
    );

    // While PRESSED or LONG_HELD the registered copy is always 1, so fall is
    // exactly "PB_debounced low"; checking it first makes release win over
    // a coinciding LONG or REPEAT threshold.
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            state   <= IDLE;
            hold    <= '0;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            LONG    <= 1'b0;
            REPEAT  <= 1'b0;
            HELD    <= 1'b0;
            COUNT   <= '0;
        end else begin
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            LONG    <= 1'b0;
            REPEAT  <= 1'b0;
            case (state)
                IDLE:
                    if (rise) begin
                        state <= PRESSED;
                        hold  <= HOLD_W'(1);
                        PRESS <= 1'b1;
                        HELD  <= 1'b1;
                        COUNT <= COUNT + COUNT_W'(1);
                    end
                PRESSED:
                    if (fall) begin
                        state   <= IDLE;
                        hold    <= '0;
                        RELEASE <= 1'b1;
                        HELD    <= 1'b0;
                    end else if (hold == LONG_M1) begin
                        state <= LONG_HELD;
                        hold  <= '0;
                        LONG  <= 1'b1;
                    end else begin
                        hold <= hold + HOLD_W'(1);
                    end
                LONG_HELD:
                    if (fall) begin
                        state   <= IDLE;
                        hold    <= '0;
                        RELEASE <= 1'b1;
                        HELD    <= 1'b0;
                    end else if (hold == REPEAT_M1) begin
                        hold   <= '0;
                        REPEAT <= 1'b1;
                        COUNT  <= COUNT + COUNT_W'(1);
                    end else begin
                        hold <= hold + HOLD_W'(1);
                    end
                default: begin
                    state <= IDLE;
                    hold  <= '0;
                    HELD  <= 1'b0;
                end
            endcase
        end
endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter LONG_CYCLES, default 1000, consecutive high samples of PB_debounced before a long-press event; legal range 2 to 2^24-1.
REQ-002 Parameter REPEAT_CYCLES, default 250, samples between auto-repeat events after a long press; legal range 1 to 2^24-1.
REQ-003 Port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port RST_N  input  1  asynchronous, active-low reset.
REQ-005 Port PB_debounced  input  1  debounced, CLK-synchronous button level from the upstream debouncer; 1 means pressed.
REQ-006 Port PRESS  output  1  one-cycle pulse on press.
REQ-007 Port RELEASE  output  1  one-cycle pulse on release.
REQ-008 Port LONG  output  1  one-cycle pulse when a press reaches LONG_CYCLES.
REQ-009 Port REPEAT  output  1  one-cycle auto-repeat pulse while a long press is held.
REQ-010 Port HELD  output  1  level; 1 while the FSM is in PRESSED or LONG_HELD.
REQ-011 Port COUNT  output  8  running event count.

Function
REQ-012 All outputs SHALL be registered; there is no combinational path from PB_debounced to any output.
REQ-013 The block SHALL keep a one-bit registered copy pb_q of PB_debounced for edge detection.
REQ-014 FSM states SHALL be IDLE, PRESSED and LONG_HELD; the block SHALL leave reset in IDLE.
REQ-015 IDLE->PRESSED: on the edge where PB_debounced=1 and pb_q=0; PRESS=1 in the following cycle only, which gives 1-cycle latency.
REQ-016 On entry to PRESSED, a 24-bit hold counter SHALL load 1 and SHALL increment on each further edge with PB_debounced=1.
REQ-017 PRESSED->LONG_HELD: on the edge where the hold counter equals LONG_CYCLES-1 and PB_debounced=1; LONG=1 for one cycle; the hold counter SHALL clear to 0.
REQ-018 In LONG_HELD, the hold counter SHALL increment each edge; when it equals REPEAT_CYCLES-1 with PB_debounced=1, REPEAT=1 for one cycle and the counter SHALL clear to 0.
REQ-019 PRESSED or LONG_HELD ->IDLE: on any edge where PB_debounced=0; RELEASE=1 for one cycle; the hold counter SHALL clear.
REQ-020 If release coincides with a LONG or REPEAT threshold edge, release SHALL win: RELEASE=1, LONG=0, REPEAT=0.
REQ-021 No two of PRESS, RELEASE, LONG and REPEAT SHALL be high in the same cycle.
REQ-022 COUNT SHALL increment by 1 on each PRESS and each REPEAT pulse (in the same cycle as the pulse), and SHALL wrap from 255 to 0; LONG and RELEASE SHALL not change COUNT.
REQ-023 HELD SHALL go to 1 in the same cycle as PRESS and to 0 in the same cycle as RELEASE.
REQ-024 A one-cycle high glitch on PB_debounced SHALL produce PRESS then RELEASE in consecutive cycles, with COUNT +1.

Reset
REQ-025 RST_N=0 SHALL immediately force IDLE, the hold counter to 0, pb_q=0, COUNT=0 and PRESS=RELEASE=LONG=REPEAT=HELD=0, independent of CLK.
REQ-026 Reset asserted mid-press SHALL not produce RELEASE.
REQ-027 After deassertion with PB_debounced already 1, the first edge SHALL be treated as a rising edge (PRESS), because pb_q resets to 0.

Structure
REQ-028 A shared include button_pkg SHALL hold the FSM state encodings (IDLE=2'd0, PRESSED=2'd1, LONG_HELD=2'd2), the hold-counter width (24) and the COUNT width (8).
REQ-029 One sub-module, edge_detect (CLK, RST_N, d, rise, fall), SHALL supply the registered rise and fall strobes; the FSM and counters SHALL live in button_event.

Verification (bench overrides LONG_CYCLES=8, REPEAT_CYCLES=4; CLK period 2 ns)
REQ-030 Short press: PB_debounced high 5 cycles -> PRESS 1 cycle after the rise, no LONG, RELEASE 1 cycle after the fall, COUNT=1, HELD high 5 cycles.
REQ-031 Long press with repeat: PB_debounced high 20 cycles -> PRESS, LONG at the 8th high sample, REPEAT at samples 12, 16 and 20 -> COUNT=4, then RELEASE.
REQ-032 Release on threshold: PB_debounced high exactly 7 samples, low on the 8th -> RELEASE, no LONG, COUNT=1.
REQ-033 Wrap: 256 short presses -> COUNT=0; the 257th press -> COUNT=1.
REQ-034 Reset mid-press: RST_N low during LONG_HELD -> all outputs 0 asynchronously, no RELEASE; deassert with PB_debounced=1 -> PRESS on the next cycle, COUNT=1.
REQ-035 Glitch: PB_debounced high 1 cycle -> PRESS and RELEASE in consecutive cycles, all four pulses mutually exclusive throughout.
